// File: rtl/sys_bridge_pkg.sv
// rtl/sys_bridge_pkg.sv - shared constants and types for the system-bus bridge and its timer
package sys_bridge_pkg;

    localparam logic [1:0] TMR_OFF_CTRL   = 2'd0;
    localparam logic [1:0] TMR_OFF_PRESET = 2'd1;
    localparam logic [1:0] TMR_OFF_COUNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // Only 2'b01 reloads; every other encoding behaves as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_e;

endpackage

// File: rtl/sys_bridge_if.sv
// rtl/sys_bridge_if.sv - CPU memory port and data-memory port bundled for the bridge
interface sys_bridge_if #(
    parameter int DM_AW = 10
);
    logic [31:0]      cpu_adr;
    logic [31:0]      cpu_wd;
    logic             cpu_we;
    logic [31:0]      cpu_rd;
    logic [DM_AW-1:0] dm_adr;
    logic [31:0]      dm_wd;
    logic             dm_we;
    logic [31:0]      dm_rd;

    modport slave (
        input  cpu_adr, cpu_wd, cpu_we, dm_rd,
        output cpu_rd, dm_adr, dm_wd, dm_we
    );

    modport master (
        output cpu_adr, cpu_wd, cpu_we, dm_rd,
        input  cpu_rd, dm_adr, dm_wd, dm_we
    );
endinterface

// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped countdown timer: CTRL/PRESET/COUNT registers, FSM and irq
module tc_timer
    import sys_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic        irq
);

    tmr_state_e  state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        irq_q, irq_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            im_q      <= 1'b0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        im_d      = im_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        // Auto-reload turns the pending flag into a one-cycle pulse.
        if (pending_q && mode_q == MODE_AUTO) begin
            pending_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                pending_d = 1'b1;
                if (mode_q == MODE_AUTO) begin
                    state_d = ST_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU register writes are applied last so they override FSM updates.
        if (we) begin
            unique case (reg_sel)
                TMR_OFF_CTRL: begin
                    en_d      = wd[CTRL_EN_BIT];
                    mode_d    = wd[CTRL_MODE_MSB:CTRL_MODE_LSB];
                    im_d      = wd[CTRL_IM_BIT];
                    pending_d = 1'b0;
                end
                TMR_OFF_PRESET: preset_d = wd;
                default: ;
            endcase
        end

        irq_d = pending_d & im_d;
    end

    always_comb begin
        rd = '0;
        unique case (reg_sel)
            TMR_OFF_CTRL:   rd = {28'd0, im_q, mode_q, en_q};
            TMR_OFF_PRESET: rd = preset_q;
            TMR_OFF_COUNT:  rd = count_q;
            default:        rd = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: rtl/sys_bridge.sv
// rtl/sys_bridge.sv - CPU bus decode between data memory and the countdown timer
module sys_bridge
    import sys_bridge_pkg::*;
#(
    parameter int          DM_AW    = 10,
    parameter logic [31:0] TMR_BASE = 32'h0000_7F00
) (
    input  logic          clk,
    input  logic          rst,
    sys_bridge_if.slave   bus,
    output logic          irq
);

    logic        dm_hit;
    logic        tmr_hit;
    logic        tmr_we;
    logic [31:0] tmr_rd;
    logic        unused_adr_lsb;

    // Byte-lane bits carry no meaning on this word-only bus.
    assign unused_adr_lsb = ^bus.cpu_adr[1:0];

    assign dm_hit  = (bus.cpu_adr[31:DM_AW+2] == '0);
    assign tmr_hit = !dm_hit
                     && (bus.cpu_adr[31:4] == TMR_BASE[31:4])
                     && (bus.cpu_adr[3:2] != 2'b11);
    assign tmr_we  = bus.cpu_we & tmr_hit;

    assign bus.dm_adr = bus.cpu_adr[DM_AW+1:2];
    assign bus.dm_wd  = bus.cpu_wd;
    assign bus.dm_we  = bus.cpu_we & dm_hit;

    always_comb begin
        bus.cpu_rd = '0;
        if (dm_hit) begin
            bus.cpu_rd = bus.dm_rd;
        end else if (tmr_hit) begin
            bus.cpu_rd = tmr_rd;
        end
    end

    tc_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .reg_sel (bus.cpu_adr[3:2]),
        .wd      (bus.cpu_wd),
        .we      (tmr_we),
        .rd      (tmr_rd),
        .irq     (irq)
    );

endmodule

// File: tb/tb_sys_bridge.sv
// tb/tb_sys_bridge.sv - directed scoreboard bench for sys_bridge
module tb_sys_bridge;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_UNUSED = 32'h0000_7F0C;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq;
    int          total  = 0;
    int          passed = 0;
    exp_t        sb_q[$];
    logic [31:0] mem [0:1023];

    sys_bridge_if #(.DM_AW(10)) bus ();

    sys_bridge #(.DM_AW(10), .TMR_BASE(32'h0000_7F00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.dm_we) mem[bus.dm_adr] <= bus.dm_wd;
    end
    assign bus.dm_rd = mem[bus.dm_adr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc_rd(input string tag, input logic [31:0] adr,
                          input logic [31:0] exp_rd, input logic exp_irq);
        exp_t e;
        e.tag = tag; e.rd = exp_rd; e.irq = exp_irq;
        sb_q.push_back(e);
        bus.cpu_adr = adr;
        bus.cpu_we  = 1'b0;
        @(negedge clk);
        e = sb_q.pop_front();
        chk({e.tag, "_rd"}, bus.cpu_rd, e.rd);
        chk({e.tag, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
        @(posedge clk); #1;
    endtask

    task automatic cyc_wr(input logic [31:0] adr, input logic [31:0] data);
        bus.cpu_adr = adr;
        bus.cpu_wd  = data;
        bus.cpu_we  = 1'b1;
        @(posedge clk); #1;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.cpu_adr = 32'h0000_0010;
        bus.cpu_wd  = 32'h0;
        bus.cpu_we  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("dm_we_in_reset", {31'd0, bus.dm_we}, 32'd1);
        @(posedge clk); #1;
        bus.cpu_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        cyc_rd("rst_ctrl",   A_CTRL,   32'h0, 1'b0);
        cyc_rd("rst_preset", A_PRESET, 32'h0, 1'b0);
        cyc_rd("rst_count",  A_COUNT,  32'h0, 1'b0);

        // Data-memory path, window boundary and miss gating.
        bus.cpu_adr = 32'h0000_0010;
        bus.cpu_wd  = 32'hDEAD_BEEF;
        bus.cpu_we  = 1'b1;
        @(negedge clk);
        chk("dm_we_hit", {31'd0, bus.dm_we}, 32'd1);
        chk("dm_adr",    {22'd0, bus.dm_adr}, 32'd4);
        chk("dm_wd",     bus.dm_wd, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        bus.cpu_we = 1'b0;
        cyc_rd("dm_rd_10", 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        cyc_wr(32'h0000_0000, 32'h0000_0011);
        cyc_wr(32'h0000_0FFC, 32'h0000_1234);
        cyc_rd("dm_top_word", 32'h0000_0FFC, 32'h0000_1234, 1'b0);
        cyc_rd("dm_past_top", 32'h0000_1000, 32'h0, 1'b0);
        bus.cpu_adr = 32'h0000_5000;
        bus.cpu_wd  = 32'h0BAD_0BAD;
        bus.cpu_we  = 1'b1;
        @(negedge clk);
        chk("miss_dm_we", {31'd0, bus.dm_we}, 32'd0);
        chk("miss_rd",    bus.cpu_rd, 32'h0);
        @(posedge clk); #1;
        bus.cpu_we = 1'b0;
        cyc_rd("dm_0_kept", 32'h0000_0000, 32'h0000_0011, 1'b0);

        // One-shot, PRESET=5, IM on.
        cyc_wr(A_PRESET, 32'd5);
        cyc_wr(A_CTRL, 32'h9);
        cyc_rd("os_pre0", A_COUNT, 32'd0, 1'b0);
        cyc_rd("os_pre1", A_COUNT, 32'd0, 1'b0);
        for (int c = 5; c >= 1; c--) cyc_rd($sformatf("os_cnt%0d", c), A_COUNT, c, 1'b0);
        cyc_rd("os_int",   A_COUNT, 32'd0, 1'b0);
        cyc_rd("os_irq",   A_COUNT, 32'd0, 1'b1);
        cyc_rd("os_ctrl",  A_CTRL,  32'h8, 1'b1);
        cyc_rd("os_hold",  A_CTRL,  32'h8, 1'b1);
        cyc_wr(A_CTRL, 32'h0);
        cyc_rd("os_clear", A_CTRL,  32'h0, 1'b0);

        // Auto-reload, PRESET=3: period of five cycles, one-cycle irq pulses.
        do_reset();
        cyc_wr(A_PRESET, 32'd3);
        cyc_wr(A_CTRL, 32'hB);
        for (int k = 0; k < 17; k++) begin
            logic [31:0] ec;
            logic        ei;
            int          ph;
            if (k < 2) begin
                ec = 0; ei = 1'b0;
            end else begin
                ph = (k - 2) % 5;
                ec = (ph < 3) ? 32'(3 - ph) : 32'd0;
                ei = (ph == 4);
            end
            cyc_rd($sformatf("ar_k%0d", k), A_COUNT, ec, ei);
        end

        // Masked interrupt.
        do_reset();
        cyc_wr(A_PRESET, 32'd2);
        cyc_wr(A_CTRL, 32'h1);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ec;
            ec = (k == 2) ? 32'd2 : (k == 3) ? 32'd1 : 32'd0;
            cyc_rd($sformatf("mask_k%0d", k), A_COUNT, ec, 1'b0);
        end
        cyc_wr(A_CTRL, 32'h8);
        cyc_rd("mask_ctrl", A_CTRL, 32'h8, 1'b0);
        cyc_rd("mask_after", A_CTRL, 32'h8, 1'b0);

        // PRESET=0 behaves as a single counting cycle.
        do_reset();
        cyc_wr(A_CTRL, 32'h9);
        cyc_rd("p0_k0", A_COUNT, 32'd0, 1'b0);
        cyc_rd("p0_k1", A_COUNT, 32'd0, 1'b0);
        cyc_rd("p0_k2", A_COUNT, 32'd0, 1'b0);
        cyc_rd("p0_int", A_COUNT, 32'd0, 1'b0);
        cyc_rd("p0_irq", A_CTRL,  32'h8, 1'b1);
        do_reset();
        cyc_rd("p0_rst_irq", A_CTRL, 32'h0, 1'b0);

        // EN cleared mid-count freezes COUNT; COUNT writes are ignored.
        cyc_wr(A_PRESET, 32'd10);
        cyc_wr(A_CTRL, 32'h1);
        cyc_rd("fr_k0", A_COUNT, 32'd0,  1'b0);
        cyc_rd("fr_k1", A_COUNT, 32'd0,  1'b0);
        cyc_rd("fr_k2", A_COUNT, 32'd10, 1'b0);
        cyc_rd("fr_k3", A_COUNT, 32'd9,  1'b0);
        cyc_wr(A_CTRL, 32'h0);
        cyc_rd("fr_k5", A_COUNT, 32'd7, 1'b0);
        cyc_rd("fr_k6", A_COUNT, 32'd7, 1'b0);
        cyc_wr(A_COUNT, 32'h55);
        cyc_rd("cnt_ro", A_COUNT, 32'd7, 1'b0);

        // Reset in the middle of counting.
        cyc_wr(A_CTRL, 32'hB);
        cyc_rd("rm_k0", A_COUNT, 32'd7,  1'b0);
        cyc_rd("rm_k1", A_COUNT, 32'd7,  1'b0);
        cyc_rd("rm_k2", A_COUNT, 32'd10, 1'b0);
        do_reset();
        cyc_rd("rm_ctrl",   A_CTRL,   32'h0, 1'b0);
        cyc_rd("rm_preset", A_PRESET, 32'h0, 1'b0);
        cyc_rd("rm_count",  A_COUNT,  32'h0, 1'b0);
        cyc_rd("rm_idle",   A_COUNT,  32'h0, 1'b0);

        // Unused offset and CTRL width.
        cyc_wr(A_PRESET, 32'h1234_5678);
        cyc_rd("unused_off", A_UNUSED, 32'h0, 1'b0);
        cyc_rd("preset_rb",  A_PRESET, 32'h1234_5678, 1'b0);
        cyc_wr(A_CTRL, 32'hFFFF_FFFF);
        cyc_rd("ctrl_width", A_CTRL, 32'h0000_000F, 1'b0);
        do_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sys_bridge.md
# sys_bridge

System-bus bridge placed directly downstream of the multicycle CPU's single memory port. It decodes the CPU address/write-data/write-enable, routes accesses to the word-addressed data memory or to an internal memory-mapped countdown timer, and returns the selected read data to the CPU in the same cycle. The timer raises an interrupt request line for the CPU's exception logic.

## Interface
- DM_AW, 10: data-memory word-address width; DM window is 0x0000_0000 .. 4*2^DM_AW-1
- TMR_BASE, 32'h0000_7F00: base byte address of the timer's 3-word register window
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- cpu_adr  in  32  byte address from CPU
- cpu_wd  in  32  CPU write data
- cpu_we  in  1  CPU memory write strobe
- cpu_rd  out  32  read data to CPU; combinational from cpu_adr
- dm_adr  out  DM_AW  word address to data memory = cpu_adr[DM_AW+1:2]
- dm_wd  out  32  = cpu_wd
- dm_we  out  1  cpu_we gated by DM-window hit
- dm_rd  in  32  data-memory read data, combinational
- irq  out  1  timer interrupt request, registered

## Operation
- Decode: DM hit when cpu_adr < 4*2^DM_AW; timer hit when cpu_adr[31:4] == TMR_BASE[31:4] and cpu_adr[3:2] != 2'b11. cpu_adr[1:0] ignored.
- Timer registers: CTRL at +0x0 (R/W), PRESET at +0x4 (R/W), COUNT at +0x8 (read-only; writes ignored).
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM (interrupt mask, 1 = enabled); [31:4] read 0, written data discarded.
- Reads: DM hit → dm_rd; timer hit → register value; miss → 32'h0. Writes on miss: dropped, no side effect.
- Timer FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT: EN=0 → IDLE (COUNT frozen). COUNT > 1 → COUNT−1. COUNT ≤ 1 → COUNT ← 0, → INT.
  - INT: set pending flag. MODE one-shot: clear EN, → IDLE. MODE auto-reload: → LOAD.
- irq = pending & IM, registered. Pending cleared by any CPU write to CTRL; in auto-reload, pending also auto-clears one cycle after set (irq is a 1-cycle pulse).
- PRESET = 0 behaves as PRESET = 1 (one counting cycle).

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, pending=0, irq=0. cpu_rd/dm_* follow inputs combinationally during reset. Reset mid-count returns to IDLE next edge.
- Register writes take effect at the edge where cpu_we=1; readback valid the following cycle.
- CPU write to CTRL in the same cycle as an FSM-driven EN clear in INT: CPU write wins.
- Write to PRESET during CNT does not alter COUNT; it is used at the next LOAD.
- Write of EN=1 at edge t → LOAD at t+1, COUNT=PRESET visible after t+2, decrements from t+3. For PRESET=N≥1: INT state N+2 cycles after the EN write, irq high one cycle later.
- Data memory: zero-latency path; no stall generation.

## Structure
- Package sys_bridge_pkg: timer register offsets, CTRL bit indices, MODE encodings, FSM state enum (2-bit).
- Sub-module tc_timer: registers, FSM, irq; bridge top holds only decode and read mux.

## Test plan
- DM path: write 0xDEADBEEF to 0x0000_0010 → dm_we=1, dm_adr=4; read same address returns dm_rd; access to 0x0000_5000 (miss, DM_AW=10) → dm_we=0, cpu_rd=0.
- One-shot: PRESET=5, CTRL=0x9 → COUNT reads 5,4,3,2,1,0; irq rises and stays high; CTRL reads EN=0; write CTRL=0 → irq low next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → irq 1-cycle pulses every 5 cycles, COUNT reloads to 3 each period.
- Mask: PRESET=2, CTRL=0x1 → count reaches 0, irq stays 0; then CTRL=0x8 clears pending, irq remains 0.
- Edge cases: write COUNT=0x55 → ignored; PRESET=0 with EN → INT after one CNT cycle; EN cleared mid-count freezes COUNT; rst asserted mid-CNT → all registers 0, irq 0 next cycle.
- Read of unused timer offset +0xC → cpu_rd=0; CTRL write 0xFFFF_FFFF → reads back 0x0000_000F.
